// File: rtl/conf_drv_pkg.sv
// Shared state encoding and sequence-length helper for the configuration shift driver.
package conf_drv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        GAP,
        LOAD,
        TAIL,
        DONE
    } t_conf_drv_state;

    localparam int CONF_EXTRA_PERIODS = 3;

    // Conf periods per sequence: one per chain bit plus GAP, LOAD and TAIL.
    function automatic int total_periods(input int conf_width);
        return conf_width + CONF_EXTRA_PERIODS;
    endfunction

endpackage

// File: rtl/conf_clk_gen.sv
// CLK_CONF divider: low for CLK_DIV cycles, then high for CLK_DIV cycles; held low when disabled.
// Strobes are single-cycle: period_start on the first low cycle, sample on the last high cycle.
module conf_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_enable,
    output logic o_clk_conf,
    output logic o_period_start,
    output logic o_sample
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] r_div;
    logic             r_clk_conf;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_div      <= '0;
            r_clk_conf <= 1'b0;
        end else if (!i_enable) begin
            r_div      <= '0;
            r_clk_conf <= 1'b0;
        end else if (r_div == DIV_LAST) begin
            r_div      <= '0;
            r_clk_conf <= ~r_clk_conf;
        end else begin
            r_div      <= r_div + 1'b1;
        end
    end

    assign o_clk_conf     = r_clk_conf;
    assign o_period_start = i_enable && !r_clk_conf && (r_div == '0);
    assign o_sample       = i_enable &&  r_clk_conf && (r_div == DIV_LAST);

endmodule

// File: rtl/conf_shift_driver.sv
// MONOPIX config-chain initiator: shifts CONF_DATA LSB-first, pulses LD_CONF, captures SO_CONF readback.
// Sequence is (CONF_WIDTH+3)*2*CLK_DIV cycles plus one DONE cycle; START is ignored (not queued) while busy.
module conf_shift_driver
    import conf_drv_pkg::*;
#(
    parameter int CONF_WIDTH = 64,
    parameter int CLK_DIV    = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [CONF_WIDTH-1:0] i_conf_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [CONF_WIDTH-1:0] o_readback,
    output logic                  o_clk_conf,
    output logic                  o_si_conf,
    output logic                  o_ld_conf,
    output logic                  o_def_conf,
    input  logic                  i_so_conf
);

    localparam int NPER   = total_periods(CONF_WIDTH);
    localparam int PCNT_W = $clog2(NPER);
    localparam logic [PCNT_W-1:0] LAST_SHIFT = PCNT_W'(CONF_WIDTH - 1);

    t_conf_drv_state       r_state, w_state_nxt;
    logic [PCNT_W-1:0]     r_period, w_period_nxt;
    logic [CONF_WIDTH-1:0] r_shadow, w_shadow_nxt, w_shadow_shr;
    logic [CONF_WIDTH-1:0] r_readback, w_readback_nxt;
    logic                  r_si, w_si_nxt;
    logic                  r_ld, w_ld_nxt;
    logic                  r_def, w_def_nxt;
    logic                  r_busy, w_busy_nxt;
    logic                  r_done, w_done_nxt;
    logic                  w_period_start;
    logic                  w_sample;

    conf_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_enable       (r_busy),
        .o_clk_conf     (o_clk_conf),
        .o_period_start (w_period_start),
        .o_sample       (w_sample)
    );

    // Pad outputs are computed one cycle ahead so they move exactly at period start.
    always_comb begin
        w_state_nxt    = r_state;
        w_period_nxt   = r_period;
        w_shadow_nxt   = r_shadow;
        w_readback_nxt = r_readback;
        w_si_nxt       = r_si;
        w_ld_nxt       = r_ld;
        w_def_nxt      = r_def;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_shadow_shr   = r_shadow >> 1;
        unique case (r_state)
            IDLE, DONE: begin
                w_state_nxt = IDLE;
                if (i_start) begin
                    w_state_nxt    = SHIFT;
                    w_period_nxt   = '0;
                    w_shadow_nxt   = i_conf_data;
                    w_readback_nxt = '0;
                    w_si_nxt       = i_conf_data[0];
                    w_ld_nxt       = 1'b0;
                    w_busy_nxt     = 1'b1;
                end
            end
            SHIFT: begin
                if (w_sample) begin
                    w_period_nxt   = r_period + 1'b1;
                    w_shadow_nxt   = w_shadow_shr;
                    w_readback_nxt = {i_so_conf, r_readback[CONF_WIDTH-1:1]};
                    if (r_period == LAST_SHIFT) begin
                        w_state_nxt = GAP;
                        w_si_nxt    = 1'b0;
                    end else begin
                        w_si_nxt    = w_shadow_shr[0];
                    end
                end
            end
            GAP: begin
                if (w_sample) begin
                    w_period_nxt = r_period + 1'b1;
                    w_state_nxt  = LOAD;
                    w_ld_nxt     = 1'b1;
                end
            end
            LOAD: begin
                if (w_sample) begin
                    w_period_nxt = r_period + 1'b1;
                    w_state_nxt  = TAIL;
                    w_ld_nxt     = 1'b0;
                end
            end
            TAIL: begin
                if (w_sample) begin
                    w_state_nxt = DONE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_def_nxt   = 1'b0;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_period   <= '0;
            r_shadow   <= '0;
            r_readback <= '0;
            r_si       <= 1'b0;
            r_ld       <= 1'b0;
            r_def      <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_period   <= w_period_nxt;
            r_shadow   <= w_shadow_nxt;
            r_readback <= w_readback_nxt;
            r_si       <= w_si_nxt;
            r_ld       <= w_ld_nxt;
            r_def      <= w_def_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // SI_CONF and LD_CONF may only move on the first cycle of a conf period.
    a_pads_stable_mid_period: assert property (@(posedge i_clk) disable iff (i_rst)
        (r_busy && $past(r_busy) && !w_period_start) |-> ($stable(r_si) && $stable(r_ld)));

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_readback = r_readback;
    assign o_si_conf  = r_si;
    assign o_ld_conf  = r_ld;
    assign o_def_conf = r_def;

endmodule

// File: tb/tb_conf_shift_driver.sv
// Scoreboarded bench for conf_shift_driver with a behavioural chip model on the pads.
module tb_conf_shift_driver;
    localparam int W   = 8;
    localparam int DIV = 2;
    localparam int PER = 2 * DIV;
    localparam int SEQ = (W + 3) * PER;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [W-1:0] data = '0;
    logic busy, done, clk_conf, si, ld, def, so;
    logic [W-1:0] rb;

    logic start1 = 1'b0;
    logic [W-1:0] data1 = '0;
    logic busy1, done1, clk_conf1, si1, ld1, def1, so1;
    logic [W-1:0] rb1;

    conf_shift_driver #(.CONF_WIDTH(W), .CLK_DIV(DIV)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_conf_data(data),
        .o_busy(busy), .o_done(done), .o_readback(rb), .o_clk_conf(clk_conf),
        .o_si_conf(si), .o_ld_conf(ld), .o_def_conf(def), .i_so_conf(so)
    );

    conf_shift_driver #(.CONF_WIDTH(W), .CLK_DIV(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start1), .i_conf_data(data1),
        .o_busy(busy1), .o_done(done1), .o_readback(rb1), .o_clk_conf(clk_conf1),
        .o_si_conf(si1), .o_ld_conf(ld1), .o_def_conf(def1), .i_so_conf(so1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Chip model: an W-bit chain, SI captured on CLK_CONF rise, chain advances on the fall,
    // and only the first W clocks of each sequence move it.
    logic [W-1:0] chain = '0, chain1 = '0, loaded = '0;
    logic pend = 1'b0, pend1 = 1'b0;
    int cnt = 0, cnt1 = 0;
    assign so  = chain[0];
    assign so1 = chain1[0];
    always @(posedge busy) cnt = 0;
    always @(posedge clk_conf) begin
        if (cnt < W) pend = si;
        if (ld) loaded = chain;
    end
    always @(negedge clk_conf) if (cnt < W) begin chain = {pend, chain[W-1:1]}; cnt++; end
    always @(posedge busy1) cnt1 = 0;
    always @(posedge clk_conf1) if (cnt1 < W) pend1 = si1;
    always @(negedge clk_conf1) if (cnt1 < W) begin chain1 = {pend1, chain1[W-1:1]}; cnt1++; end

    int vectors = 0;
    int errors  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference model: a request is accepted iff the previous sequence has reached DONE.
    typedef struct {
        logic [W-1:0] d;
        logic [W-1:0] rb;
        int           t;
    } exp_t;
    exp_t q[$];
    int free_edge = 0;
    int last_t = 0;
    logic [W-1:0] exp_chain = '0;

    task automatic drive(input logic s, input logic [W-1:0] d);
        exp_t e;
        @(negedge clk);
        start = s;
        data  = d;
        if (s && !rst && (cyc + 1 >= free_edge)) begin
            e.d = d; e.rb = exp_chain; e.t = cyc;
            q.push_back(e);
            exp_chain = d;
            last_t    = cyc;
            free_edge = cyc + SEQ + 2;
        end
    endtask

    task automatic idle_until(input int c);
        for (int i = 0; i < 200 && cyc < c; i++) drive(1'b0, W'($urandom));
    endtask

    task automatic drain();
        for (int i = 0; i < 3 * SEQ && q.size() != 0; i++) drive(1'b0, W'($urandom));
        drive(1'b0, W'($urandom));
        check("queue_drained", 64'(q.size()), 64'd0);
    endtask

    // Monitor: tracks pad activity of the running sequence and scores it when DONE appears.
    exp_t me;
    int m_t = 0, rises = 0, ld_first = -1, ld_cnt = 0, clk_err = 0, gap_si_err = 0;
    logic m_active = 1'b0, prev_busy = 1'b0, prev_clk = 1'b0, exp_clk;
    logic [W-1:0] si_word = '0;
    always @(negedge clk) begin
        if (rst) begin
            m_active = 1'b0; prev_busy = 1'b0; prev_clk = 1'b0;
        end else begin
            if (busy && !prev_busy) begin
                m_active = 1'b1; m_t = cyc - 1; rises = 0; ld_first = -1;
                ld_cnt = 0; clk_err = 0; gap_si_err = 0; si_word = '0;
            end
            if (m_active && busy) begin
                exp_clk = (((cyc - m_t - 1) % PER) >= DIV);
                if (clk_conf !== exp_clk) clk_err++;
                if (clk_conf && !prev_clk) begin
                    if (rises < W) si_word[rises] = si;
                    else if (rises == W && si !== 1'b0) gap_si_err++;
                    rises++;
                end
                if (ld) begin
                    if (ld_first < 0) ld_first = cyc;
                    ld_cnt++;
                end
            end
            if (done) begin
                if (q.size() == 0) begin
                    vectors++; errors++;
                    $display("FAIL unexpected_done: DONE seen at cycle %0d, required none", cyc);
                end else begin
                    me = q.pop_front();
                    check("done_cycle", 64'(cyc), 64'(me.t + 1 + SEQ));
                    check("busy_rise_cycle", 64'(m_t), 64'(me.t));
                    check("readback", 64'(rb), 64'(me.rb));
                    check("si_bits_at_rises", 64'(si_word), 64'(me.d));
                    check("chip_loaded_word", 64'(loaded), 64'(me.d));
                    check("clk_conf_rises", 64'(rises), 64'(W + 3));
                    check("gap_si_zero_errs", 64'(gap_si_err), 64'd0);
                    check("ld_first_cycle", 64'(ld_first), 64'(me.t + 1 + (W + 1) * PER));
                    check("ld_width", 64'(ld_cnt), 64'(PER));
                    check("clk_conf_shape_errs", 64'(clk_err), 64'd0);
                    check("def_at_done", 64'(def), 64'd0);
                    check("busy_at_done", 64'(busy), 64'd0);
                    m_active = 1'b0;
                end
            end
            prev_busy = busy;
            prev_clk  = clk_conf;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    int t1, done_at, tog_err;
    logic pb, pc;
    logic [W-1:0] d1, exp1;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_readback", 64'(rb), 64'd0);
        check("rst_clk_conf", 64'(clk_conf), 64'd0);
        check("rst_si", 64'(si), 64'd0);
        check("rst_ld", 64'(ld), 64'd0);
        check("rst_def", 64'(def), 64'd1);
        chain = 8'h3C;
        exp_chain = 8'h3C;
        rst = 1'b0;

        // First load with chip readback of 8'h3C, then a second load returning 8'hA5.
        drive(1'b1, 8'hA5);
        idle_until(last_t + SEQ);
        check("def_before_first_done", 64'(def), 64'd1);
        check("busy_last_tail_cycle", 64'(busy), 64'd1);
        drain();
        drive(1'b1, 8'h00);
        drain();

        // START during BUSY is ignored; CONF_DATA changes after acceptance have no effect.
        drive(1'b1, W'($urandom));
        t1 = last_t;
        idle_until(t1 + 4);
        drive(1'b0, W'($urandom));
        idle_until(t1 + 9);
        drive(1'b1, W'($urandom));
        drain();

        // START held high: back-to-back sequences with zero idle gap.
        for (int i = 0; i < 100; i++) drive(1'b1, W'($urandom));
        drain();

        // Asynchronous reset in the middle of a sequence.
        drive(1'b1, W'($urandom));
        t1 = last_t;
        idle_until(t1 + 20);
        #1 rst = 1'b1;
        #1;
        check("midrst_clk_conf", 64'(clk_conf), 64'd0);
        check("midrst_si", 64'(si), 64'd0);
        check("midrst_ld", 64'(ld), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_def", 64'(def), 64'd1);
        check("midrst_done", 64'(done), 64'd0);
        q.delete();
        free_edge = 0;
        repeat (2) @(negedge clk);
        chain = W'($urandom);
        exp_chain = chain;
        rst = 1'b0;
        idle_until(cyc + 5);
        drive(1'b1, W'($urandom));
        drain();

        // CLK_DIV=1 instance: CLK_CONF toggles every cycle, DONE at t+23.
        chain1 = W'($urandom);
        exp1 = chain1;
        d1 = W'($urandom);
        @(negedge clk);
        start1 = 1'b1; data1 = d1; t1 = cyc;
        @(negedge clk);
        start1 = 1'b0; data1 = ~d1;
        check("div1_busy_rise", 64'(busy1), 64'd1);
        done_at = -1; tog_err = 0; pb = 1'b0; pc = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (busy1 && pb && (clk_conf1 === pc)) tog_err++;
            if (done1 && done_at < 0) done_at = cyc;
            pb = busy1; pc = clk_conf1;
            @(negedge clk);
        end
        check("div1_done_cycle", 64'(done_at), 64'(t1 + 1 + (W + 3) * 2));
        check("div1_toggle_errs", 64'(tog_err), 64'd0);
        check("div1_readback", 64'(rb1), 64'(exp1));
        check("div1_chip_chain", 64'(chain1), 64'(d1));
        check("div1_def", 64'(def1), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/conf_shift_driver.md
# conf_shift_driver

FPGA-side initiator for the MONOPIX configuration shift chain. Takes a parallel configuration word, serialises it LSB-first onto SI_CONF with a divided-down CLK_CONF, then issues the LD_CONF load pulse. It captures SO_CONF as readback of the previous chain contents and manages DEF_CONF release. It sits between the readout firmware register bank and the chip's configuration pads.

## Interface
- CONF_WIDTH, 64: length of the chip configuration chain in bits (equals the width of t_conf).
- CLK_DIV, 4: CLK cycles per half period of CLK_CONF; minimum 1.

- CLK  in  1  system clock. One clock domain; all logic on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- START  in  1  request a configuration cycle; sampled only while BUSY=0.
- CONF_DATA  in  CONF_WIDTH  word to shift; bit 0 is shifted first.
- BUSY  out  1  sequence in progress.
- DONE  out  1  one-CLK pulse at the end of a sequence.
- READBACK  out  CONF_WIDTH  SO_CONF bits captured during the last sequence.
- CLK_CONF  out  1  configuration clock to the chip.
- SI_CONF  out  1  serial data to the chip.
- LD_CONF  out  1  load strobe to the chip.
- DEF_CONF  out  1  default-configuration select to the chip.
- SO_CONF  in  1  serial data from the chip.

## Operation
- Reset values:
  - CLK_CONF=0, SI_CONF=0, LD_CONF=0, BUSY=0, DONE=0, READBACK=0.
  - DEF_CONF=1.
- States:
  - IDLE → SHIFT: on START with BUSY=0. CONF_DATA is latched into the shadow register on the same edge.
  - SHIFT: periods 0..CONF_WIDTH-1. SI_CONF=data[p] for the whole of period p.
  - GAP: one period, SI_CONF=0.
  - LOAD: one period, LD_CONF=1.
  - TAIL: one period, LD_CONF=0.
  - DONE: single cycle that pulses DONE, then returns to IDLE.
- Conf period: 2*CLK_DIV CLK cycles. CLK_CONF is low for the first CLK_DIV cycles and high for the second CLK_DIV. SI_CONF and LD_CONF change only at period start, i.e. at the CLK_CONF falling edge. CLK_CONF toggles in every state except IDLE, where it is held at 0.
- Readback:
  - READBACK[p] samples SO_CONF in the last CLK cycle of the high half of SHIFT period p. This sampling point absorbs pad and chip output delay.
  - READBACK is cleared to 0 when START is accepted.
- DEF_CONF:
  - Stays 1 from reset until the first sequence reaches DONE, then drops to 0 in that same cycle.
  - Stays 0 on all later sequences until the next RST.
- START while BUSY=1 is ignored; no queueing. CONF_DATA changes after acceptance have no effect.

## Timing
- START is accepted on edge t. BUSY=1 and CLK_CONF=0 from t+1.
- The first CLK_CONF rise is at t+1+CLK_DIV.
- LD_CONF is high from t+1+(CONF_WIDTH+1)*2*CLK_DIV for 2*CLK_DIV cycles.
- DONE=1 and BUSY=0 at cycle t+1+(CONF_WIDTH+3)*2*CLK_DIV.
- START may be reasserted in the DONE cycle. It is accepted because BUSY=0 is sampled that cycle, so back-to-back sequences have zero idle gap.
- All chip-pad outputs are driven directly from flops; there is no combinational path from inputs.
- RST mid-sequence: all outputs take their reset values immediately, including DEF_CONF=1, which restores the chip defaults. Any partial shift is abandoned.

## Structure
- conf_drv_pkg: state enum t_conf_drv_state (IDLE, SHIFT, GAP, LOAD, TAIL, DONE) and a localparam helper for total period count (CONF_WIDTH+3).
- Sub-module conf_clk_gen:
  - Inputs: CLK, RST, enable.
  - Outputs: CLK_CONF plus one-cycle strobes period_start and sample (last high-half cycle).
  - Implementation: a CLK_DIV-wide divider counter.
- Top FSM holds a period counter of $clog2(CONF_WIDTH+3) bits and a shift/readback shadow register.

## Test plan
Use CONF_WIDTH=8 and CLK_DIV=2 throughout (period = 4 CLK cycles, sequence = 44 cycles).

- **First load.** After RST, START with CONF_DATA=8'hA5 at t. Required:
  - SI_CONF sequence 1,0,1,0,0,1,0,1 sampled at CLK_CONF rises.
  - 8 rises, then LD_CONF high for 4 cycles from t+37.
  - DONE at t+45.
  - DEF_CONF 1→0 at t+45.
- **Readback.** Chip model holds chain 8'h3C and shifts out LSB first; sequence with 8'hA5. Required:
  - READBACK=8'h3C.
  - A second sequence with 8'h00 returns READBACK=8'hA5.
- **Ignored START.** START pulsed at t+10 during BUSY. Required:
  - No change to the sequence.
  - DONE at t+45 only.
  - CONF_DATA changed at t+5 is not shifted.
- **Back-to-back.** START held high continuously. Required:
  - Second sequence BUSY rises at t+46, with CLK_CONF low through its first half period.
  - DEF_CONF stays 0.
- **Reset mid-sequence.** RST asserted at t+20 asynchronously, between CLK edges. Required:
  - Immediately: CLK_CONF=0, SI_CONF=0, LD_CONF=0, BUSY=0, DEF_CONF=1.
  - No DONE pulse.
  - After release, a new START runs a full 44-cycle sequence.
- **CLK_DIV=1 corner.** Rebuild with CLK_DIV=1 and START. Required:
  - CLK_CONF toggles every cycle.
  - Sequence completes with DONE at t+23.
  - READBACK is still correct.
